recv_control: RTL
=================

# recv_control

Receive-side controller of the debug unit, the counterpart of the transmit sequencer. It consumes 32-bit words delivered by the UART receive path and loads them sequentially into instruction memory until an end marker arrives. It then decodes command words that run or single-step the CPU. When execution stops, it raises `send_flag` to start the state dump and waits for `send_done` before accepting the next command.

## Interface
- `IM_ADDR_LENGTH`, 32: instruction-memory address width.
- `IM_MEM_SIZE`, 1024: number of instruction words; the last valid address is `IM_MEM_SIZE-1`.
- `NBITS`, 32: UART word and instruction width.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `rx_Data`  in  NBITS  received word; valid only in the cycle `rx_done`=1.
- `rx_done`  in  1  one-cycle pulse per received word.
- `halt`  in  1  CPU has retired the halt instruction; level.
- `send_done`  in  1  one-cycle pulse from the transmit sequencer when the dump is complete.
- `IM_Addr`  out  IM_ADDR_LENGTH  instruction-memory write address.
- `IM_Data`  out  NBITS  instruction-memory write data.
- `IM_we`  out  1  instruction-memory write strobe.
- `cpu_enable`  out  1  CPU clock-enable.
- `send_flag`  out  1  request to the transmit sequencer.

## Operation
- States are one-hot: LOAD, CMD, RUN, STEP, DUMP. The reset state is LOAD.
- All outputs are registered. Reset values: `IM_Addr`=0, `IM_Data`=0, `IM_we`=0, `cpu_enable`=0, `send_flag`=0. The internal write pointer also resets to 0.
- **LOAD**, on `rx_done`:
  - Register `IM_Data`=`rx_Data` and `IM_Addr`=pointer, set `IM_we`=1, and increment the pointer.
  - If `rx_Data`==32'hFFFFFFFF, the marker is still written, then the state goes to CMD.
  - If pointer==`IM_MEM_SIZE-1` and the word is not the marker, the word is written and the state goes to CMD (memory full). The pointer does not wrap.
  - Without `rx_done`, `IM_we`=0.
- **CMD**, on `rx_done`, decode `rx_Data`:
  - 32'h00000001: go to RUN.
  - 32'h00000002: go to STEP.
  - 32'h00000003: clear the pointer to 0 and go to LOAD.
  - Any other value is ignored and the state stays CMD.
- **RUN**:
  - `cpu_enable`=1 while `halt`=0.
  - When `halt` is sampled 1, `cpu_enable` goes to 0 and `send_flag` goes to 1, both registered on the same edge. The state goes to DUMP.
  - If `halt` is already 1 on entry, `cpu_enable` never rises; go straight to DUMP with `send_flag`=1.
- **STEP**: `cpu_enable`=1 for exactly one cycle, then `cpu_enable`=0, `send_flag`=1, and the state goes to DUMP.
- **DUMP**:
  - Hold `send_flag`=1 and `cpu_enable`=0 until `send_done`.
  - On `send_done`, `send_flag`=0 and the state goes to CMD.
- `rx_done` is ignored in RUN, STEP and DUMP; words are dropped.
- `send_done` outside DUMP is ignored.
- A reset at any point returns to LOAD with the pointer at 0 and all outputs at 0 on assertion; a pending write is abandoned.

## Timing
- Write latency: `IM_we`/`IM_Addr`/`IM_Data` are valid in the cycle after the `rx_done` cycle and last exactly one cycle.
- Command latency: `cpu_enable` rises one cycle after the `rx_done` that carries the run or step command.
- Halt to dump: `send_flag` rises one cycle after `halt` is first sampled 1.
- Dump to command: `send_flag` falls one cycle after `send_done`, and a command is accepted from the next cycle onward.
- Back-to-back `rx_done` on consecutive cycles is supported in LOAD: one write per cycle with consecutive addresses.

## Configuration
- `RECV_CTRL_STEP_EN`:
  - Defined: the STEP state and command 32'h00000002 exist as described.
  - Undefined: STEP is not implemented, 32'h00000002 is treated as an unknown command and ignored, and the block stays in CMD.

## Test plan
- **Load and marker.** Words 0x20010005, 0x20020007, 0xFFFFFFFF as three `rx_done` pulses.
  - Expect writes at addresses 0, 1, 2 with those data, `IM_we` high exactly three single cycles, then CMD.
- **Memory full.** With `IM_MEM_SIZE`=4, send 5 non-marker words.
  - Expect writes at addresses 0–3, then the fifth word is treated as a command; an unknown value leaves CMD and produces no write.
- **Run to halt.** Load, send 0x00000001, hold `halt` low 10 cycles, then raise it.
  - Expect `cpu_enable` high 10 cycles, then low with `send_flag`=1.
  - `send_done` pulse: `send_flag` low next cycle, back to CMD.
- **Step.** Send 0x00000002.
  - Expect `cpu_enable` high exactly one cycle, `send_flag` high until `send_done`.
  - Repeat twice, each producing one enable cycle; with the macro undefined, no enable.
- **Ignored traffic.**
  - During DUMP, send `rx_done` with 0x00000001: no state change.
  - Send 0x00000003 in CMD, then a new word: it is written at address 0.
- **Reset mid-operation.** Assert `reset` during RUN with `cpu_enable`=1.
  - All outputs are 0 immediately; after release, the first received word is written at address 0.

Source files
------------

// File: rtl/recv_control.sv
// -----------------------------------------------------------------------------
// recv_control
//   Receive-side controller of the debug unit. It loads words from the UART
//   receive path into instruction memory until an end marker arrives or the
//   memory is full. It then decodes command words that run or single-step the
//   CPU. When execution stops it requests a state dump and waits for the
//   transmit sequencer to report that the dump is finished.
//
//   Optional feature macro: RECV_CTRL_STEP_EN
//     defined   : single-step command (32'h2) and the STEP state exist
//     undefined : 32'h2 is an unknown command and is ignored
//
// Ports
//   clk, reset     clock; asynchronous active-high reset
//   rx_Data        received word, valid while rx_done=1
//   rx_done        one-cycle pulse per received word
//   halt           CPU has retired the halt instruction (level)
//   send_done      one-cycle pulse when the dump is complete
//   IM_Addr        instruction-memory write address (registered)
//   IM_Data        instruction-memory write data (registered)
//   IM_we          instruction-memory write strobe (registered)
//   cpu_enable     CPU clock enable (registered)
//   send_flag      dump request to the transmit sequencer (registered)
// -----------------------------------------------------------------------------
module recv_control #(
    parameter int IM_ADDR_LENGTH = 32,
    parameter int IM_MEM_SIZE    = 1024,
    parameter int NBITS          = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NBITS-1:0]          rx_Data,
    input  logic                      rx_done,
    input  logic                      halt,
    input  logic                      send_done,
    output logic [IM_ADDR_LENGTH-1:0] IM_Addr,
    output logic [NBITS-1:0]          IM_Data,
    output logic                      IM_we,
    output logic                      cpu_enable,
    output logic                      send_flag
);

    typedef enum logic [4:0] {
        LOAD = 5'b00001,
        CMD  = 5'b00010,
        RUN  = 5'b00100,
        STEP = 5'b01000,
        DUMP = 5'b10000
    } state_e;

    localparam logic [NBITS-1:0]          MARKER     = '1;
    localparam logic [NBITS-1:0]          CMD_RUN    = NBITS'(1);
    localparam logic [NBITS-1:0]          CMD_RELOAD = NBITS'(3);
    localparam logic [IM_ADDR_LENGTH-1:0] LAST_ADDR  = IM_ADDR_LENGTH'(IM_MEM_SIZE - 1);

    state_e                      state_q, state_d;
    logic [IM_ADDR_LENGTH-1:0]   ptr_q, ptr_d;
    logic [IM_ADDR_LENGTH-1:0]   im_addr_q, im_addr_d;
    logic [NBITS-1:0]            im_data_q, im_data_d;
    logic                        im_we_q, im_we_d;
    logic                        cpu_en_q, cpu_en_d;
    logic                        send_flag_q, send_flag_d;

    logic cmd_run, cmd_reload, load_last;

    assign cmd_run    = (rx_Data == CMD_RUN);
    assign cmd_reload = (rx_Data == CMD_RELOAD);
    // Marker or final address both end the load phase; the word is still written.
    assign load_last  = (rx_Data == MARKER) || (ptr_q == LAST_ADDR);

`ifdef RECV_CTRL_STEP_EN
    localparam logic [NBITS-1:0] CMD_STEP = NBITS'(2);
    logic cmd_step;
    assign cmd_step = (rx_Data == CMD_STEP);
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= LOAD;
        else       state_q <= state_d;
    end

    // Datapath / output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q       <= '0;
            im_addr_q   <= '0;
            im_data_q   <= '0;
            im_we_q     <= 1'b0;
            cpu_en_q    <= 1'b0;
            send_flag_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            im_addr_q   <= im_addr_d;
            im_data_q   <= im_data_d;
            im_we_q     <= im_we_d;
            cpu_en_q    <= cpu_en_d;
            send_flag_q <= send_flag_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD: if (rx_done && load_last) state_d = CMD;
            CMD: begin
                if (rx_done) begin
                    // A run command with halt already high skips RUN entirely.
                    if (cmd_run)         state_d = halt ? DUMP : RUN;
`ifdef RECV_CTRL_STEP_EN
                    else if (cmd_step)   state_d = STEP;
`endif
                    else if (cmd_reload) state_d = LOAD;
                end
            end
            RUN:  if (halt) state_d = DUMP;
`ifdef RECV_CTRL_STEP_EN
            STEP: state_d = DUMP;
`endif
            DUMP: if (send_done) state_d = CMD;
            default: state_d = LOAD;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        ptr_d       = ptr_q;
        im_addr_d   = im_addr_q;
        im_data_d   = im_data_q;
        im_we_d     = 1'b0;
        cpu_en_d    = 1'b0;
        send_flag_d = 1'b0;
        case (state_q)
            LOAD: begin
                if (rx_done) begin
                    im_data_d = rx_Data;
                    im_addr_d = ptr_q;
                    im_we_d   = 1'b1;
                    // Pointer saturates at the last address instead of wrapping.
                    if (ptr_q != LAST_ADDR) ptr_d = ptr_q + IM_ADDR_LENGTH'(1);
                end
            end
            CMD: begin
                if (rx_done) begin
                    if (cmd_run) begin
                        cpu_en_d    = !halt;
                        send_flag_d = halt;
                    end
`ifdef RECV_CTRL_STEP_EN
                    else if (cmd_step) begin
                        cpu_en_d = 1'b1;
                    end
`endif
                    else if (cmd_reload) begin
                        ptr_d = '0;
                    end
                end
            end
            RUN: begin
                cpu_en_d    = !halt;
                send_flag_d = halt;
            end
`ifdef RECV_CTRL_STEP_EN
            STEP: send_flag_d = 1'b1;
`endif
            DUMP: send_flag_d = !send_done;
            default: ;
        endcase
    end

    assign IM_Addr    = im_addr_q;
    assign IM_Data    = im_data_q;
    assign IM_we      = im_we_q;
    assign cpu_enable = cpu_en_q;
    assign send_flag  = send_flag_q;

endmodule
